// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive controller slice.
//   - Default widths for payload, FIFO address and baud divisor.
//   - Capture-state encoding used by uart_rx_ctrl.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS_DEF = 8;   // payload bits per frame
  localparam int ADDR_BITS_DEF = 2;   // FIFO depth = 2**ADDR_BITS_DEF
  localparam int DIV_BITS_DEF  = 11;  // baud divisor width

  // Frame capture progress: waiting for the parity verdict, or parity seen
  // and waiting for the end-of-frame pulse.
  typedef enum logic [0:0] {
    WAIT_PAR  = 1'b0,
    WAIT_DONE = 1'b1
  } cap_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Show-ahead FIFO holding received frames ({err, data}) for the consumer.
//
// Ports
//   clk        in   clock, all logic on posedge
//   Reset      in   synchronous active-high reset (pointers and level only)
//   push       in   write request; accepted if not full or popping same cycle
//   push_data  in   entry to store
//   pop        in   consumer ready; a pop only happens when valid
//   head       out  head entry, forced to zero while empty
//   valid      out  FIFO not empty
//   full       out  FIFO holds 2**Addr_bits entries
//   level      out  stored entry count
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int Width     = 9,
  parameter int Addr_bits = 2
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 push,
  input  logic [Width-1:0]     push_data,
  input  logic                 pop,
  output logic [Width-1:0]     head,
  output logic                 valid,
  output logic                 full,
  output logic [Addr_bits:0]   level
);

  localparam int Depth = 2 ** Addr_bits;

  logic [Width-1:0]     mem [Depth];
  logic [Addr_bits-1:0] wr_ptr;
  logic [Addr_bits-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign valid = (level != '0);
  assign full  = (level == (Addr_bits+1)'(Depth));

  // Popping an empty FIFO does nothing; a full FIFO still accepts a push when
  // the head leaves in the same cycle (the write lands in the slot being freed).
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);

  // Zero the head while empty so the read port is clean after reset.
  assign head = valid ? mem[rd_ptr] : '0;

  // NOTE: storage has no reset; only pointers and level define what is valid,
  // which keeps the array a plain RAM without a reset network.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are exactly Addr_bits wide, so increments wrap modulo the depth.
  always_ff @(posedge clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Control wrapper around a UART receiver: generates the oversampling tick,
// pairs each frame with its parity verdict and queues {err, data} in a
// show-ahead FIFO with sticky overrun and an optional parity-error counter.
//
// Build option
//   UART_RX_CTRL_ERRCNT_EN  defined: err_count is a saturating 8-bit count of
//                           frames completed with a parity error (accepted
//                           or dropped). Undefined: err_count is tied to 0.
//
// Ports
//   clk           in   clock, all logic on posedge
//   Reset         in   synchronous active-high reset
//   en            in   block enable (gates tick counter and frame capture)
//   divisor       in   s_ticks period minus one, in clk cycles
//   s_ticks       out  one-cycle oversampling tick to the receiver
//   rx_done_tick  in   frame-complete pulse from the receiver
//   rx_data       in   received payload, valid with rx_done_tick
//   parity_ok     in   one-cycle parity-match pulse before rx_done_tick
//   rd_data       out  FIFO head payload
//   rd_err        out  parity-error flag of the FIFO head
//   rd_valid      out  FIFO not empty
//   rd_ready      in   consumer accepts head
//   overrun       out  sticky frame-dropped flag
//   clr_overrun   in   clears overrun (a same-cycle drop wins)
//   err_count     out  saturating parity-error count
//   fifo_level    out  stored entry count
// -----------------------------------------------------------------------------
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int Data_bits = DATA_BITS_DEF,
  parameter int Addr_bits = ADDR_BITS_DEF,
  parameter int Div_bits  = DIV_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 en,
  input  logic [Div_bits-1:0]  divisor,
  output logic                 s_ticks,
  input  logic                 rx_done_tick,
  input  logic [Data_bits-1:0] rx_data,
  input  logic                 parity_ok,
  output logic [Data_bits-1:0] rd_data,
  output logic                 rd_err,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic                 overrun,
  input  logic                 clr_overrun,
  output logic [7:0]           err_count,
  output logic [Addr_bits:0]   fifo_level
);

  localparam logic [0:0] ST_WAIT_PAR  = WAIT_PAR;
  localparam logic [0:0] ST_WAIT_DONE = WAIT_DONE;

  // ---------------------------------------------------------------------------
  // Oversampling tick generator
  // ---------------------------------------------------------------------------
  // The divisor is sampled into div_q only at a wrap (or while idle), so a
  // change mid-period never strands the counter above a smaller new limit.
  logic [Div_bits-1:0] tick_cnt;
  logic [Div_bits-1:0] div_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (Reset || !en) begin
      tick_cnt <= '0;
      div_q    <= divisor;
      s_ticks  <= 1'b0;
    end else if (tick_cnt == div_q) begin
      tick_cnt <= '0;
      div_q    <= divisor;
      s_ticks  <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
      s_ticks  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame capture FSM
  // ---------------------------------------------------------------------------
  logic [0:0] state;
  logic       par_seen;
  logic       push;
  logic       err;

  assign push = en & rx_done_tick;
  // parity_ok arriving in the same cycle as rx_done_tick still counts.
  assign err  = ~(par_seen | parity_ok);

  always_ff @(posedge clk) begin
    if (Reset || !en) begin
      state    <= ST_WAIT_PAR;
      par_seen <= 1'b0;
    end else if (rx_done_tick) begin
      state    <= ST_WAIT_PAR;
      par_seen <= 1'b0;
    end else if (state == ST_WAIT_PAR && parity_ok) begin
      state    <= ST_WAIT_DONE;
      par_seen <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FIFO
  // ---------------------------------------------------------------------------
  logic [Data_bits:0] head;
  logic               fifo_full;
  logic               drop;

  uart_rx_fifo #(
    .Width     (Data_bits + 1),
    .Addr_bits (Addr_bits)
  ) u_fifo (
    .clk       (clk),
    .Reset     (Reset),
    .push      (push),
    .push_data ({err, rx_data}),
    .pop       (rd_ready),
    .head      (head),
    .valid     (rd_valid),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  assign rd_err  = head[Data_bits];
  assign rd_data = head[Data_bits-1:0];

  // When full, rd_valid is necessarily high, so rd_ready alone frees a slot.
  assign drop = push & fifo_full & ~rd_ready;

  always_ff @(posedge clk) begin
    if (Reset) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Parity-error counter (optional)
  // ---------------------------------------------------------------------------
`ifdef UART_RX_CTRL_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (Reset) begin
      err_count <= '0;
    end else if (push && err && err_count != 8'hFF) begin
      err_count <= err_count + 1'b1;
    end
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Directed self-checking bench for uart_rx_ctrl. Inputs are driven and
// outputs sampled on the falling edge, half a cycle from the active edge.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

`ifdef UART_RX_CTRL_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic        clk;
  logic        Reset;
  logic        en;
  logic [10:0] divisor;
  logic        s_ticks;
  logic        rx_done_tick;
  logic [7:0]  rx_data;
  logic        parity_ok;
  logic [7:0]  rd_data;
  logic        rd_err;
  logic        rd_valid;
  logic        rd_ready;
  logic        overrun;
  logic        clr_overrun;
  logic [7:0]  err_count;
  logic [2:0]  fifo_level;

  int n_checks = 0;
  int n_fail   = 0;
  int n_errs   = 0;   // parity-error frames since the last reset

  uart_rx_ctrl dut (
    .clk          (clk),
    .Reset        (Reset),
    .en           (en),
    .divisor      (divisor),
    .s_ticks      (s_ticks),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .parity_ok    (parity_ok),
    .rd_data      (rd_data),
    .rd_err       (rd_err),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .overrun      (overrun),
    .clr_overrun  (clr_overrun),
    .err_count    (err_count),
    .fifo_level   (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_errs();
    return ERRCNT ? 8'(n_errs) : 8'd0;
  endfunction

  task automatic apply_reset();
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
  endtask

  // Optional parity_ok pulse, then rx_done_tick with data; returns at the
  // falling edge right after the push edge.
  task automatic send_frame(input logic [7:0] data, input bit with_par, input bit pop_same);
    if (with_par) begin
      parity_ok = 1'b1;
      @(negedge clk);
      parity_ok = 1'b0;
    end
    rx_done_tick = 1'b1;
    rx_data      = data;
    rd_ready     = pop_same;
    @(negedge clk);
    rx_done_tick = 1'b0;
    rd_ready     = 1'b0;
    if (!with_par && en) n_errs++;
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  // Counts falling edges until s_ticks is seen high; 99 if it never comes.
  task automatic cycles_to_tick(output int n);
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (s_ticks) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    en = 1'b1; divisor = 11'd3;
    apply_reset();
    n_errs = 0;
    n_checks++;
    if ({s_ticks, rd_valid, rd_err, rd_data, overrun, err_count, fifo_level} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got tick=%b v=%b e=%b d=%h ovr=%b ec=%0d lvl=%0d want all zero",
               s_ticks, rd_valid, rd_err, rd_data, overrun, err_count, fifo_level);
    end
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ticks();
    int n;
    divisor = 11'd3;
    en = 1'b1;
    cycles_to_tick(n);
    n_checks++;
    if (n !== 4) begin n_fail++; $display("FAIL tick_first: got %0d cycles want 4", n); end
    cycles_to_tick(n);
    n_checks++;
    if (n !== 4) begin n_fail++; $display("FAIL tick_period: got %0d cycles want 4", n); end
    // Stop two cycles into the next period.
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (s_ticks !== 1'b0) begin n_fail++; $display("FAIL tick_disabled: got %b want 0 at cycle %0d", s_ticks, i); end
    end
    en = 1'b1;
    cycles_to_tick(n);
    n_checks++;
    if (n !== 4) begin n_fail++; $display("FAIL tick_restart_align: got %0d cycles want 4", n); end
    // divisor = 0 ticks every cycle.
    en = 1'b0; divisor = 11'd0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (s_ticks !== 1'b1) begin n_fail++; $display("FAIL tick_div0: got %b want 1 at cycle %0d", s_ticks, i); end
      @(negedge clk);
    end
    divisor = 11'd3;
  endtask

  task automatic test_parity_ok_frame();
    send_frame(8'hA5, 1'b1, 1'b0);
    n_checks++;
    if ({rd_valid, rd_err, rd_data, fifo_level} !== {1'b1, 1'b0, 8'hA5, 3'd1}) begin
      n_fail++;
      $display("FAIL good_frame: got v=%b e=%b d=%h lvl=%0d want v=1 e=0 d=a5 lvl=1",
               rd_valid, rd_err, rd_data, fifo_level);
    end
    pop_one();
    n_checks++;
    if ({rd_valid, fifo_level} !== {1'b0, 3'd0}) begin
      n_fail++; $display("FAIL good_frame_pop: got v=%b lvl=%0d want v=0 lvl=0", rd_valid, fifo_level);
    end
  endtask

  task automatic test_parity_err_frame();
    send_frame(8'h3C, 1'b0, 1'b0);
    n_checks++;
    if ({rd_valid, rd_err, rd_data} !== {1'b1, 1'b1, 8'h3C}) begin
      n_fail++; $display("FAIL bad_frame: got v=%b e=%b d=%h want v=1 e=1 d=3c", rd_valid, rd_err, rd_data);
    end
    n_checks++;
    if (err_count !== exp_errs()) begin
      n_fail++; $display("FAIL bad_frame_errcnt: got %0d want %0d", err_count, exp_errs());
    end
    pop_one();
  endtask

  task automatic test_overrun();
    logic [7:0] frames [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (frames[i]) send_frame(frames[i], 1'b1, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0);   // dropped, still counted as an error
    n_checks++;
    if ({fifo_level, overrun, rd_data, rd_err} !== {3'd4, 1'b1, 8'h11, 1'b0}) begin
      n_fail++; $display("FAIL overrun_full: got lvl=%0d ovr=%b d=%h e=%b want lvl=4 ovr=1 d=11 e=0",
                         fifo_level, overrun, rd_data, rd_err);
    end
    n_checks++;
    if (err_count !== exp_errs()) begin
      n_fail++; $display("FAIL overrun_errcnt: got %0d want %0d", err_count, exp_errs());
    end
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b want 0", overrun); end
    // A drop in the same cycle as the clear keeps the flag set.
    parity_ok = 1'b1;
    @(negedge clk);
    parity_ok = 1'b0; rx_done_tick = 1'b1; rx_data = 8'h77; clr_overrun = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0; clr_overrun = 1'b0;
    n_checks++;
    if ({overrun, fifo_level} !== {1'b1, 3'd4}) begin
      n_fail++; $display("FAIL overrun_set_wins: got ovr=%b lvl=%0d want ovr=1 lvl=4", overrun, fifo_level);
    end
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] expect_q [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
    send_frame(8'h66, 1'b1, 1'b1);
    n_checks++;
    if ({fifo_level, overrun, rd_data} !== {3'd4, 1'b0, 8'h22}) begin
      n_fail++; $display("FAIL full_push_pop: got lvl=%0d ovr=%b d=%h want lvl=4 ovr=0 d=22",
                         fifo_level, overrun, rd_data);
    end
    foreach (expect_q[i]) begin
      n_checks++;
      if ({rd_valid, rd_data, rd_err} !== {1'b1, expect_q[i], 1'b0}) begin
        n_fail++; $display("FAIL drain_%0d: got v=%b d=%h e=%b want v=1 d=%h e=0",
                           i, rd_valid, rd_data, rd_err, expect_q[i]);
      end
      pop_one();
    end
    n_checks++;
    if ({rd_valid, rd_data, fifo_level} !== {1'b0, 8'h00, 3'd0}) begin
      n_fail++; $display("FAIL drain_empty: got v=%b d=%h lvl=%0d want v=0 d=00 lvl=0", rd_valid, rd_data, fifo_level);
    end
    // Push with rd_ready while empty performs only the push.
    send_frame(8'h88, 1'b1, 1'b1);
    n_checks++;
    if ({fifo_level, rd_data} !== {3'd1, 8'h88}) begin
      n_fail++; $display("FAIL empty_push_pop: got lvl=%0d d=%h want lvl=1 d=88", fifo_level, rd_data);
    end
    pop_one();
  endtask

  task automatic test_enable_gate();
    send_frame(8'h5A, 1'b1, 1'b0);
    en = 1'b0;
    send_frame(8'hEE, 1'b0, 1'b0);   // ignored while disabled
    n_checks++;
    if ({fifo_level, rd_data, rd_err} !== {3'd1, 8'h5A, 1'b0}) begin
      n_fail++; $display("FAIL en_off_hold: got lvl=%0d d=%h e=%b want lvl=1 d=5a e=0", fifo_level, rd_data, rd_err);
    end
    pop_one();
    n_checks++;
    if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL en_off_pop: got lvl=%0d want 0", fifo_level); end
    // parity_ok while disabled must not be remembered.
    parity_ok = 1'b1;
    @(negedge clk);
    parity_ok = 1'b0;
    en = 1'b1;
    send_frame(8'hC3, 1'b0, 1'b0);
    n_checks++;
    if ({rd_err, rd_data, err_count} !== {1'b1, 8'hC3, exp_errs()}) begin
      n_fail++; $display("FAIL en_par_ignored: got e=%b d=%h ec=%0d want e=1 d=c3 ec=%0d",
                         rd_err, rd_data, err_count, exp_errs());
    end
    pop_one();
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'h02, 1'b1, 1'b0);
    parity_ok = 1'b1;              // capture now in WAIT_DONE
    @(negedge clk);
    parity_ok = 1'b0;
    apply_reset();
    n_errs = 0;
    n_checks++;
    if ({s_ticks, rd_valid, rd_err, rd_data, overrun, err_count, fifo_level} !== '0) begin
      n_fail++;
      $display("FAIL midframe_reset: got tick=%b v=%b e=%b d=%h ovr=%b ec=%0d lvl=%0d want all zero",
               s_ticks, rd_valid, rd_err, rd_data, overrun, err_count, fifo_level);
    end
    send_frame(8'h9D, 1'b0, 1'b0);
    n_checks++;
    if ({rd_valid, rd_err, rd_data, err_count} !== {1'b1, 1'b1, 8'h9D, exp_errs()}) begin
      n_fail++; $display("FAIL after_reset_frame: got v=%b e=%b d=%h ec=%0d want v=1 e=1 d=9d ec=%0d",
                         rd_valid, rd_err, rd_data, err_count, exp_errs());
    end
  endtask

  initial begin
    Reset = 1'b1; en = 1'b0; divisor = 11'd3;
    rx_done_tick = 1'b0; rx_data = 8'h00; parity_ok = 1'b0;
    rd_ready = 1'b0; clr_overrun = 1'b0;
    @(negedge clk);
    test_reset();
    test_ticks();
    test_parity_ok_frame();
    test_parity_err_frame();
    test_overrun();
    test_full_push_pop();
    test_enable_gate();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter Data_bits, default 8, payload width per frame.
REQ-002 SHALL have parameter Addr_bits, default 2, FIFO depth 2**Addr_bits (4).
REQ-003 SHALL have parameter Div_bits, default 11, width of the baud divisor.
REQ-004 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-005 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port en  in  1  block enable.
REQ-007 SHALL have port divisor  in  Div_bits  s_ticks period minus one, in clk cycles.
REQ-008 SHALL have port s_ticks  out  1  oversampling tick to the receiver.
REQ-009 SHALL have port rx_done_tick  in  1  frame-complete pulse from the receiver.
REQ-010 SHALL have port rx_data  in  Data_bits  received payload, valid with rx_done_tick.
REQ-011 SHALL have port parity_ok  in  1  one-cycle parity-match pulse, issued before rx_done_tick.
REQ-012 SHALL have port rd_data  out  Data_bits  FIFO head payload.
REQ-013 SHALL have port rd_err  out  1  parity-error flag of the FIFO head.
REQ-014 SHALL have port rd_valid  out  1  FIFO not empty.
REQ-015 SHALL have port rd_ready  in  1  consumer accepts head.
REQ-016 SHALL have port overrun  out  1  sticky frame-dropped flag.
REQ-017 SHALL have port clr_overrun  in  1  clears overrun.
REQ-018 SHALL have port err_count  out  8  saturating parity-error count.
REQ-019 SHALL have port fifo_level  out  Addr_bits+1  stored entry count.

Function
REQ-020 Tick counter SHALL count 0..divisor while en=1, pulse s_ticks for one cycle at count==divisor, then wrap to 0; divisor=0 gives s_ticks every cycle.
REQ-021 en=0 SHALL hold the tick counter at 0 with s_ticks=0; a divisor change SHALL take effect at the next wrap.
REQ-022 Capture FSM SHALL have states WAIT_PAR and WAIT_DONE; WAIT_PAR->WAIT_DONE on parity_ok=1, latching par_seen=1.
REQ-023 On rx_done_tick in either state, the SHALL push {err, rx_data} with err = ~(par_seen | parity_ok), clear par_seen, and go to WAIT_PAR.
REQ-024 rx_done_tick and parity_ok in WAIT_PAR SHALL be ignored while en=0; en=0 SHALL force WAIT_PAR and clear par_seen.
REQ-025 FIFO SHALL be show-ahead: rd_valid = (fifo_level != 0); rd_data/rd_err present the head; pop on rd_valid & rd_ready.
REQ-026 Latency SHALL be one cycle: rx_done_tick in cycle N gives rd_valid=1 in cycle N+1 when previously empty.
REQ-027 Push when full without a same-cycle pop SHALL drop the frame, leave contents unchanged and set overrun.
REQ-028 Push when full with a same-cycle pop SHALL be accepted; fifo_level SHALL stay at 2**Addr_bits.
REQ-029 Pointers SHALL wrap modulo 2**Addr_bits; push and pop when empty SHALL only perform the push.
REQ-030 overrun SHALL clear on clr_overrun; a same-cycle set SHALL win.
REQ-031 The FIFO SHALL retain its contents, and allow reads, while en=0.

Reset
REQ-032 Reset SHALL clear the tick counter, pointers and par_seen, and force WAIT_PAR, regardless of the in-flight frame.
REQ-033 On the cycle after Reset, outputs SHALL be s_ticks=0, rd_valid=0, rd_err=0, rd_data=0, overrun=0, err_count=0, fifo_level=0.

Configuration
REQ-034 With UART_RX_CTRL_ERRCNT_EN defined, err_count SHALL increment, saturating at 255, on every accepted-or-dropped rx_done_tick with err=1.
REQ-035 Without UART_RX_CTRL_ERRCNT_EN, err_count SHALL be constant 0 and no counter SHALL be synthesised.

Structure
REQ-036 Package uart_pkg SHALL hold the capture-state enum and the default Data_bits, Addr_bits and Div_bits constants.
REQ-037 FIFO storage, pointers and level SHALL be the sub-module uart_rx_fifo; tick generation and the FSM SHALL reside in uart_rx_ctrl.

Verification
REQ-038 divisor=3, en=1 -> s_ticks every 4th cycle; en=0 mid-count -> s_ticks=0 and the restart is aligned to count 0.
REQ-039 parity_ok pulse then rx_done_tick with rx_data=8'hA5 -> rd_valid next cycle, rd_data=8'hA5, rd_err=0.
REQ-040 rx_done_tick with rx_data=8'h3C and no parity_ok -> rd_err=1 and err_count=1 (macro on) or 0 (macro off).
REQ-041 Five frames pushed, rd_ready=0 -> fifo_level=4, overrun=1, head = first frame; clr_overrun -> overrun=0.
REQ-042 FIFO full, rx_done_tick and rd_ready=1 same cycle -> level stays 4, overrun stays 0, new frame at tail.
REQ-043 Reset asserted in WAIT_DONE with 2 entries stored -> all REQ-033 values next cycle; a following frame gets err=1.
